// File: rtl/core_pkg.sv
// Shared tile-engine definitions: tile geometry, buffer states, rotation codes.
package core_pkg;

  localparam int unsigned P_DIM   = 8;
  localparam int unsigned P_BUS_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } tile_state_e;

  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  // Counter-clockwise rotation by d equals clockwise rotation by (4 - d) mod 4.
  function automatic logic [1:0] eff_rot(input logic [1:0] degrees, input logic direction);
    return direction ? degrees : 2'(2'd0 - degrees);
  endfunction

endpackage

// File: rtl/core_tile_buf_if.sv
// DMA/core_set facing signal bundle of the tile buffer.
interface core_tile_buf_if;

  logic [31:0] I_TB_RDATA;
  logic        I_TB_DMA_READY;
  logic        I_TB_WRITE;
  logic        I_TB_IMEM_PAD;
  logic [1:0]  I_TB_DEGREES;
  logic        I_TB_DIRECTION;
  logic        I_TB_CLEAR;
  logic [31:0] O_TB_WDATA;
  logic        O_TB_FULL;
  logic        O_TB_EMPTY;
  logic        O_TB_ERR;

  modport slave (
    input  I_TB_RDATA, I_TB_DMA_READY, I_TB_WRITE, I_TB_IMEM_PAD,
    input  I_TB_DEGREES, I_TB_DIRECTION, I_TB_CLEAR,
    output O_TB_WDATA, O_TB_FULL, O_TB_EMPTY, O_TB_ERR
  );

  modport master (
    output I_TB_RDATA, I_TB_DMA_READY, I_TB_WRITE, I_TB_IMEM_PAD,
    output I_TB_DEGREES, I_TB_DIRECTION, I_TB_CLEAR,
    input  O_TB_WDATA, O_TB_FULL, O_TB_EMPTY, O_TB_ERR
  );

endinterface

// File: rtl/core_tile_map.sv
// Maps an output (drain-order) index to the stored pixel index for a rotation.
module core_tile_map #(
  parameter  int unsigned P_DIM = 8,
  localparam int unsigned RC_W  = $clog2(P_DIM),
  localparam int unsigned IDX_W = 2 * RC_W
) (
  input  logic [IDX_W-1:0] k,
  input  logic [1:0]       e,
  output logic [IDX_W-1:0] src_c
);
  import core_pkg::*;

  localparam logic [RC_W-1:0] LAST = RC_W'(P_DIM - 1);

  logic [RC_W-1:0] r;
  logic [RC_W-1:0] c;
  logic [RC_W-1:0] sr;
  logic [RC_W-1:0] sc;

  assign r = k[IDX_W-1:RC_W];
  assign c = k[RC_W-1:0];

  // Source row/column for each quarter turn.
  always_comb begin
    sr = r;
    sc = c;
    case (e)
      P_DEG_90:  begin sr = LAST - c; sc = r;        end
      P_DEG_180: begin sr = LAST - r; sc = LAST - c; end
      P_DEG_270: begin sr = c;        sc = LAST - r; end
      default:   begin sr = r;        sc = c;        end
    endcase
  end

  assign src_c = {sr, sc};

endmodule

// File: rtl/core_tile_buf.sv
// Single-tile pixel buffer: fills a P_DIM x P_DIM tile in raster order and
// drains it rotated, with a registered, prefetched drain data path.
module core_tile_buf #(
  parameter int unsigned P_PIX_W = 24,
  parameter int unsigned P_DIM   = core_pkg::P_DIM
) (
  input  logic           I_TB_HCLK,
  input  logic           I_TB_HRESET_N,
  core_tile_buf_if.slave bus
);
  import core_pkg::*;

  localparam int unsigned CELLS = P_DIM * P_DIM;
  localparam int unsigned IDX_W = 2 * $clog2(P_DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  tile_state_e        state;
  logic [IDX_W-1:0]   wr_cnt;
  logic [IDX_W-1:0]   rd_cnt;
  logic [1:0]         rot;
  logic [P_BUS_W-1:0] wdata;
  logic               full;
  logic               empty;
  logic               err;
  logic [P_PIX_W-1:0] mem [CELLS];

  logic               fill_beat;
  logic               drain_beat;
  logic               fill_ok;
  logic               drain_ok;
  logic               last_fill;
  logic               bad_beat;
  logic [P_PIX_W-1:0] pix_in;
  logic [1:0]         rot_live;
  logic [IDX_W-1:0]   map_k;
  logic [1:0]         map_e;
  logic [IDX_W-1:0]   src;
  logic [P_PIX_W-1:0] rd_pix;
  logic               unused_rdata_c;

  assign fill_beat  = bus.I_TB_DMA_READY & ~bus.I_TB_WRITE;
  assign drain_beat = bus.I_TB_DMA_READY &  bus.I_TB_WRITE;
  assign fill_ok    = fill_beat  & ((state == ST_EMPTY) | (state == ST_FILL));
  assign drain_ok   = drain_beat & ((state == ST_FULL)  | (state == ST_DRAIN));
  assign bad_beat   = (fill_beat & ~fill_ok) | (drain_beat & ~drain_ok);
  assign last_fill  = fill_ok & (wr_cnt == LAST_IDX);
  assign pix_in     = bus.I_TB_IMEM_PAD ? '0 : bus.I_TB_RDATA[P_PIX_W-1:0];
  assign rot_live   = eff_rot(bus.I_TB_DEGREES, bus.I_TB_DIRECTION);
  assign unused_rdata_c = ^bus.I_TB_RDATA[P_BUS_W-1:P_PIX_W];

  // Prefetch k=0 with the live rotation on the closing fill beat, else the next drain index.
  assign map_k = last_fill ? '0 : rd_cnt + IDX_W'(1);
  assign map_e = last_fill ? rot_live : rot;

  core_tile_map #(.P_DIM(P_DIM)) u_map (
    .k     (map_k),
    .e     (map_e),
    .src_c (src)
  );

  // The final pixel is still being written when k=0 may already need it.
  assign rd_pix = (last_fill && (src == wr_cnt)) ? pix_in : mem[src];

  // Pixel store: one write port, no reset.
  always_ff @(posedge I_TB_HCLK) begin
    if (I_TB_HRESET_N && fill_ok && !bus.I_TB_CLEAR) mem[wr_cnt] <= pix_in;
  end

  // Buffer state, counters, held rotation and registered outputs.
  always_ff @(posedge I_TB_HCLK or negedge I_TB_HRESET_N) begin
    if (!I_TB_HRESET_N) begin
      state  <= ST_EMPTY;
      wr_cnt <= '0;
      rd_cnt <= '0;
      rot    <= P_DEG_0;
      wdata  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      err    <= 1'b0;
    end else if (bus.I_TB_CLEAR) begin
      state  <= ST_EMPTY;
      wr_cnt <= '0;
      rd_cnt <= '0;
      rot    <= P_DEG_0;
      wdata  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      err    <= 1'b0;
    end else begin
      if (bad_beat) err <= 1'b1;
      if (fill_ok) begin
        wr_cnt <= wr_cnt + IDX_W'(1);
        empty  <= 1'b0;
        if (last_fill) begin
          state <= ST_FULL;
          full  <= 1'b1;
          rot   <= rot_live;
          wdata <= P_BUS_W'(rd_pix);
        end else begin
          state <= ST_FILL;
        end
      end
      if (drain_ok) begin
        wdata <= P_BUS_W'(rd_pix);
        if (rd_cnt == LAST_IDX) begin
          state  <= ST_EMPTY;
          rd_cnt <= '0;
          full   <= 1'b0;
          empty  <= 1'b1;
        end else begin
          state  <= ST_DRAIN;
          rd_cnt <= rd_cnt + IDX_W'(1);
        end
      end
    end
  end

  assign bus.O_TB_WDATA = wdata;
  assign bus.O_TB_FULL  = full;
  assign bus.O_TB_EMPTY = empty;
  assign bus.O_TB_ERR   = err;

endmodule

// File: doc/core_tile_buf.md
CORE_TILE_BUF -- requirements
Module: core_tile_buf

Interface
REQ-001 SHALL have parameter P_PIX_W, default 24, bits per stored pixel.
REQ-002 SHALL have parameter P_DIM, default 8, tile edge in pixels; 64 entries total.
REQ-003 SHALL have I_TB_HCLK  in  1  the single clock; all state on its rising edge.
REQ-004 SHALL have I_TB_HRESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have I_TB_RDATA  in  32  read beat from DMA; pixel in [23:0].
REQ-006 SHALL have I_TB_DMA_READY  in  1  beat qualifier; one beat per high cycle.
REQ-007 SHALL have I_TB_WRITE  in  1  from core_set: 0 = fill (read) phase, 1 = drain (write) phase.
REQ-008 SHALL have I_TB_IMEM_PAD  in  1  from core_set: current fill beat is padding.
REQ-009 SHALL have I_TB_DEGREES  in  2  rotation code 0/90/180/270.
REQ-010 SHALL have I_TB_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise.
REQ-011 SHALL have I_TB_CLEAR  in  1  synchronous flush to EMPTY, clears error.
REQ-012 SHALL have O_TB_WDATA  out  32  drain beat to DMA; [31:24] always 0.
REQ-013 SHALL have O_TB_FULL  out  1  high in FULL and DRAIN.
REQ-014 SHALL have O_TB_EMPTY  out  1  high in EMPTY only.
REQ-015 SHALL have O_TB_ERR  out  1  sticky protocol-violation flag.

Function
REQ-016 Fill beat = I_TB_DMA_READY & !I_TB_WRITE; drain beat = I_TB_DMA_READY & I_TB_WRITE.
REQ-017 States: EMPTY, FILL, FULL, DRAIN; 6-bit wr_cnt, 6-bit rd_cnt.
REQ-018 EMPTY->FILL on first fill beat; FILL->FULL on the fill beat with wr_cnt==63; FULL->DRAIN on first drain beat; DRAIN->EMPTY on the drain beat with rd_cnt==63.
REQ-019 Each accepted fill beat writes mem[wr_cnt] <= pad ? 0 : I_TB_RDATA[23:0], then wr_cnt increments; row = wr_cnt[5:3], col = wr_cnt[2:0].
REQ-020 Effective rotation e = I_TB_DIRECTION ? I_TB_DEGREES : (4 - I_TB_DEGREES) mod 4.
REQ-021 Output index k (r=k[5:3], c=k[2:0]) maps to source: e=0 (r,c); e=1 (7-c,r); e=2 (7-r,7-c); e=3 (c,7-r).
REQ-022 O_TB_WDATA SHALL be registered; on FILL->FULL it loads the mapped pixel for k=0 (prefetch); each accepted drain beat presents the current value and loads the pixel for k=rd_cnt+1, giving zero-bubble back-to-back beats.
REQ-023 The final fill write and its k=0 prefetch in the same cycle SHALL forward the incoming pixel when the mapped index is 63.
REQ-024 Fill beats in FULL/DRAIN and drain beats in EMPTY/FILL SHALL be ignored (no state, counter, or memory change) and set O_TB_ERR.
REQ-025 I_TB_DEGREES/I_TB_DIRECTION are sampled at FILL->FULL and held until EMPTY; mid-tile changes have no effect.
REQ-026 I_TB_CLEAR SHALL win over simultaneous beats: state EMPTY, counters 0, O_TB_WDATA 0, O_TB_ERR 0; memory contents unchanged.
REQ-027 Counters wrap 63->0 at tile boundary only through the state transition; no partial-tile drain.

Reset
REQ-028 Assertion of I_TB_HRESET_N low SHALL immediately force EMPTY, wr_cnt=rd_cnt=0, O_TB_WDATA=0, O_TB_FULL=0, O_TB_EMPTY=1, O_TB_ERR=0, held rotation=0.
REQ-029 Memory array is not reset; reset mid-tile discards the tile.
REQ-030 Deassertion SHALL be usable synchronously; first beat accepted on the first edge after release.

Structure
REQ-031 State encodings, degree codes (P_DEG_0..P_DEG_270), and P_DIM SHALL reside in shared package core_pkg, reused by core_set.
REQ-032 Index mapping SHALL be a combinational sub-module core_tile_map (k, e -> source index).
REQ-033 Memory SHALL be a 64 x P_PIX_W flop array, one write port, one read port.

Verification
REQ-034 Fill pixels 0..63 (value = index), cw, deg 0 -> drain beats 0..63 in order, O_TB_ERR=0, ends EMPTY.
REQ-035 Same fill, cw, deg 1 -> drain beat 0 = 56, beat 1 = 48, beat 8 = 57, beat 63 = 7.
REQ-036 Same fill, ccw, deg 1 -> identical to cw deg 3: beat 0 = 7, beat 1 = 15, beat 63 = 56; cw deg 2 -> beat 0 = 63.
REQ-037 Fill with I_TB_IMEM_PAD high on col 7 of each row, deg 0 -> drain beats 7,15,...,63 = 0.
REQ-038 Drain beat while FILL, and fill beat while FULL -> O_TB_ERR=1 sticky, counters unchanged; I_TB_CLEAR -> EMPTY, ERR=0.
REQ-039 Assert reset at fill beat 30, refill 64 -> drain reflects only new data; O_TB_EMPTY=1 immediately during reset.
